// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and types for the block RAM slice
package mem_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 18;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

   // Index width for a SIZE-deep array; a single-word array still needs one bit.
   function automatic int idx_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction
endpackage

// File: rtl/block_ram_port.sv
// rtl/block_ram_port.sv - per-port range check, write-first bypass and output register
module block_ram_port
   import mem_pkg::*;
#(
   parameter int SIZE = 2048
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  we,
   input  addr_t addr,
   input  word_t din,
   input  word_t rd_word,
   output logic  in_range,
   output word_t dout
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(SIZE);

   // One extra bit so SIZE = 65536 still compares correctly.
   assign in_range = {1'b0, addr} < LIMIT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
      end else if (!in_range) begin
         dout <= '0;
      end else if (we) begin
         dout <= din;
      end else begin
         dout <= rd_word;
      end
   end

endmodule

// File: rtl/block_ram.sv
// rtl/block_ram.sv - dual-port single-clock RAM, port A wins write collisions
module block_ram
   import mem_pkg::*;
#(
   parameter int    SIZE      = 2048,
   parameter string INIT_FILE = ""
) (
   input  logic  clka,
   input  logic  rst,
   input  logic  wea,
   input  logic  web,
   input  addr_t addra,
   input  addr_t addrb,
   input  word_t dina,
   input  word_t dinb,
   output word_t douta,
   output word_t doutb
);

   localparam int IDX_W = idx_width(SIZE);

   word_t            mem [SIZE];
   logic [IDX_W-1:0] idx_a;
   logic [IDX_W-1:0] idx_b;
   logic             in_range_a;
   logic             in_range_b;
   logic             wr_a;
   logic             wr_b;
   word_t            rd_a;
   word_t            rd_b;

   // The array itself is never reset so it maps onto block RAM.
   initial begin
      for (int i = 0; i < SIZE; i++) mem[i] = '0;
   end

   assign idx_a = addra[IDX_W-1:0];
   assign idx_b = addrb[IDX_W-1:0];

   assign wr_a = wea & in_range_a & ~rst;
   assign wr_b = web & in_range_b & ~rst & ~(wr_a && (addra == addrb));

   always_ff @(posedge clka) begin
      if (wr_a) mem[idx_a] <= dina;
      if (wr_b) mem[idx_b] <= dinb;
   end

   // Pre-edge contents feed the port registers, giving read-first across ports.
   assign rd_a = mem[idx_a];
   assign rd_b = mem[idx_b];

   block_ram_port #(.SIZE(SIZE)) u_port_a (
      .clk      (clka),
      .rst      (rst),
      .we       (wea),
      .addr     (addra),
      .din      (dina),
      .rd_word  (rd_a),
      .in_range (in_range_a),
      .dout     (douta)
   );

   block_ram_port #(.SIZE(SIZE)) u_port_b (
      .clk      (clka),
      .rst      (rst),
      .we       (web),
      .addr     (addrb),
      .din      (dinb),
      .rd_word  (rd_b),
      .in_range (in_range_b),
      .dout     (doutb)
   );

endmodule

// File: tb/tb_block_ram.sv
// tb/tb_block_ram.sv - directed self-checking bench for block_ram
module tb_block_ram;
   logic        clka;
   logic        rst;
   logic        wea;
   logic        web;
   logic [15:0] addra;
   logic [15:0] addrb;
   logic [17:0] dina;
   logic [17:0] dinb;
   logic [17:0] douta;
   logic [17:0] doutb;

   int passed = 0;
   int total  = 0;

   block_ram #(.SIZE(2048), .INIT_FILE("")) dut (
      .clka  (clka),
      .rst   (rst),
      .wea   (wea),
      .web   (web),
      .addra (addra),
      .addrb (addrb),
      .dina  (dina),
      .dinb  (dinb),
      .douta (douta),
      .doutb (doutb)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic idle();
      wea = 1'b0;
      web = 1'b0;
      dina = '0;
      dinb = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      addra = '0;
      addrb = '0;
      repeat (2) step();
      total++; if (douta !== 18'h0) $display("FAIL reset_douta got=%h exp=%h", douta, 18'h0); else passed++;
      total++; if (doutb !== 18'h0) $display("FAIL reset_doutb got=%h exp=%h", doutb, 18'h0); else passed++;
      rst = 1'b0;
      wea = 1'b1; addra = 16'd5; dina = 18'h2ABCD;
      addrb = 16'd5;
      step();
      total++; if (douta !== 18'h2ABCD) $display("FAIL wr5_douta got=%h exp=%h", douta, 18'h2ABCD); else passed++;
      total++; if (doutb !== 18'h0) $display("FAIL wr5_doutb_old got=%h exp=%h", doutb, 18'h0); else passed++;
      idle();
      step();
      total++; if (doutb !== 18'h2ABCD) $display("FAIL rd5_doutb got=%h exp=%h", doutb, 18'h2ABCD); else passed++;
      #2 rst = 1'b1;
      #1;
      total++; if (douta !== 18'h0) $display("FAIL async_rst_douta got=%h exp=%h", douta, 18'h0); else passed++;
      total++; if (doutb !== 18'h0) $display("FAIL async_rst_doutb got=%h exp=%h", doutb, 18'h0); else passed++;
      wea = 1'b1; addra = 16'd5; dina = 18'h15555;
      step();
      total++; if (douta !== 18'h0) $display("FAIL rst_hold_douta got=%h exp=%h", douta, 18'h0); else passed++;
      rst = 1'b0;
      idle();
      addra = 16'd5; addrb = 16'd5;
      step();
      total++; if (douta !== 18'h2ABCD) $display("FAIL post_rst_douta got=%h exp=%h", douta, 18'h2ABCD); else passed++;
      total++; if (doutb !== 18'h2ABCD) $display("FAIL post_rst_doutb got=%h exp=%h", doutb, 18'h2ABCD); else passed++;
   endtask

   task automatic test_basic();
      wea = 1'b1; addra = 16'd0;    dina = 18'h3FFFF;
      web = 1'b1; addrb = 16'd2047; dinb = 18'h00001;
      step();
      total++; if (douta !== 18'h3FFFF) $display("FAIL basic_wf_douta got=%h exp=%h", douta, 18'h3FFFF); else passed++;
      total++; if (doutb !== 18'h00001) $display("FAIL basic_wf_doutb got=%h exp=%h", doutb, 18'h00001); else passed++;
      idle();
      addra = 16'd2047; addrb = 16'd0;
      step();
      total++; if (douta !== 18'h00001) $display("FAIL basic_rd_douta got=%h exp=%h", douta, 18'h00001); else passed++;
      total++; if (doutb !== 18'h3FFFF) $display("FAIL basic_rd_doutb got=%h exp=%h", doutb, 18'h3FFFF); else passed++;
   endtask

   task automatic test_write_first();
      idle();
      web = 1'b1; addrb = 16'd10; dinb = 18'h11111;
      step();
      idle();
      wea = 1'b1; addra = 16'd10; dina = 18'h22222;
      addrb = 16'd10;
      step();
      total++; if (douta !== 18'h22222) $display("FAIL wf_douta got=%h exp=%h", douta, 18'h22222); else passed++;
      total++; if (doutb !== 18'h11111) $display("FAIL xport_old_doutb got=%h exp=%h", doutb, 18'h11111); else passed++;
      idle();
      step();
      total++; if (doutb !== 18'h22222) $display("FAIL xport_new_doutb got=%h exp=%h", doutb, 18'h22222); else passed++;
   endtask

   task automatic test_collision();
      wea = 1'b1; addra = 16'd7; dina = 18'h0AAAA;
      web = 1'b1; addrb = 16'd7; dinb = 18'h05555;
      step();
      total++; if (douta !== 18'h0AAAA) $display("FAIL coll_wf_douta got=%h exp=%h", douta, 18'h0AAAA); else passed++;
      total++; if (doutb !== 18'h05555) $display("FAIL coll_wf_doutb got=%h exp=%h", doutb, 18'h05555); else passed++;
      idle();
      step();
      total++; if (douta !== 18'h0AAAA) $display("FAIL coll_rd_douta got=%h exp=%h", douta, 18'h0AAAA); else passed++;
      total++; if (doutb !== 18'h0AAAA) $display("FAIL coll_rd_doutb got=%h exp=%h", doutb, 18'h0AAAA); else passed++;
      dina = 18'h3FFFF; dinb = 18'h3FFFF;
      step();
      total++; if (douta !== 18'h0AAAA) $display("FAIL we_low_douta got=%h exp=%h", douta, 18'h0AAAA); else passed++;
      step();
      total++; if (doutb !== 18'h0AAAA) $display("FAIL we_low_doutb got=%h exp=%h", doutb, 18'h0AAAA); else passed++;
   endtask

   task automatic test_out_of_range();
      idle();
      wea = 1'b1; addra = 16'd2048; dina = 18'h12345;
      addrb = 16'd2048;
      step();
      total++; if (douta !== 18'h0) $display("FAIL oor_wr_douta got=%h exp=%h", douta, 18'h0); else passed++;
      total++; if (doutb !== 18'h0) $display("FAIL oor_rd_doutb got=%h exp=%h", doutb, 18'h0); else passed++;
      idle();
      addra = 16'd0; addrb = 16'hFFFF;
      step();
      total++; if (douta !== 18'h3FFFF) $display("FAIL oor_nowrap_douta got=%h exp=%h", douta, 18'h3FFFF); else passed++;
      total++; if (doutb !== 18'h0) $display("FAIL oor_max_doutb got=%h exp=%h", doutb, 18'h0); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [17:0] exp;
      for (int i = 0; i < 16; i++) begin
         wea = 1'b1; addra = 16'(i); dina = 18'(i);
         step();
         exp = 18'(i);
         total++; if (douta !== exp) $display("FAIL b2b_wr%0d douta got=%h exp=%h", i, douta, exp); else passed++;
      end
      idle();
      for (int i = 0; i < 16; i++) begin
         addrb = 16'(i);
         if (i > 0) begin
            #3;
            exp = 18'(i - 1);
            total++; if (doutb !== exp) $display("FAIL b2b_hold%0d doutb got=%h exp=%h", i, doutb, exp); else passed++;
         end
         step();
         exp = 18'(i);
         total++; if (doutb !== exp) $display("FAIL b2b_rd%0d doutb got=%h exp=%h", i, doutb, exp); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_write_first();
      test_collision();
      test_out_of_range();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
